// File: rtl/dfd_unpack_pkg.sv
// Shared configuration, entry type and ring-pointer arithmetic for the
// DFD trace unpack FIFO and its gather network.
package dfd_unpack_pkg;

    localparam int NUM_IN    = 4;
    localparam int NUM_OUT   = 8;
    localparam int DATA_SIZE = 10;
    localparam int DEPTH     = 16;   // power of 2, >= NUM_IN + NUM_OUT

    localparam int PTR_W     = $clog2(DEPTH);
    localparam int OCC_W     = $clog2(DEPTH + 1);
    localparam int IN_CNT_W  = $clog2(NUM_IN + 1);
    localparam int OUT_CNT_W = $clog2(NUM_OUT + 1);
    localparam int LANE_W    = $clog2(NUM_IN);

    typedef logic [DATA_SIZE-1:0] entry_t;

    // DEPTH is a power of 2, so dropping the carry out of PTR_W is the mod.
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] ptr,
                                                 input logic [OCC_W-1:0] inc);
        logic [OCC_W-1:0] sum;
        sum = OCC_W'(ptr) + inc;
        return sum[PTR_W-1:0];
    endfunction

endpackage

// File: rtl/ring_gather.sv
// Right-rotates the ring by rd_ptr so the oldest entry lands on lane 0;
// lanes at or above rd_avail are forced to zero.
module ring_gather
    import dfd_unpack_pkg::*;
(
    input  entry_t [DEPTH-1:0]     ring,
    input  logic   [PTR_W-1:0]     rd_ptr,
    input  logic   [OUT_CNT_W-1:0] rd_avail,
    output entry_t [NUM_OUT-1:0]   lanes
);

    // NOTE: every variable written in always_comb gets a default first so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        lanes = '0;
        for (int j = 0; j < NUM_OUT; j++) begin
            if (OUT_CNT_W'(j) < rd_avail) begin
                lanes[j] = ring[ptr_add(rd_ptr, OCC_W'(j))];
            end
        end
    end

endmodule

// File: rtl/lane_unpack_fifo.sv
// Variable-count circular entry buffer: scatters up to NUM_IN entries per cycle
// into the ring and presents up to NUM_OUT oldest entries lane-0-aligned.
module lane_unpack_fifo
    import dfd_unpack_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic   [IN_CNT_W-1:0]  wr_cnt,
    input  entry_t [NUM_IN-1:0]    wr_data,
    output entry_t [NUM_OUT-1:0]   rd_data,
    output logic   [OUT_CNT_W-1:0] rd_avail,
    input  logic   [OUT_CNT_W-1:0] rd_pop_cnt,
    output logic   [OCC_W-1:0]     occupancy,
    output logic                   err
);

    logic   [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic   [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic   [OCC_W-1:0] occ_q, occ_d;
    logic               err_q, err_d;
    entry_t [DEPTH-1:0] ring_q, ring_d;

    logic               cnt_ok, push_bad, pop_bad, push_fire, pop_fire;
    logic   [OCC_W-1:0] push_cnt, pop_cnt, free_cnt;
    logic   [PTR_W-1:0] offset;

    // Status depends on registered occupancy only: no input-to-output path.
    assign free_cnt  = OCC_W'(DEPTH) - occ_q;
    assign wr_ready  = free_cnt >= OCC_W'(NUM_IN);
    assign rd_avail  = (occ_q >= OCC_W'(NUM_OUT)) ? OUT_CNT_W'(NUM_OUT)
                                                  : occ_q[OUT_CNT_W-1:0];
    assign occupancy = occ_q;
    assign err       = err_q;

    always_comb begin
        cnt_ok    = (wr_cnt != '0) && (wr_cnt <= IN_CNT_W'(NUM_IN));
        push_bad  = wr_valid && !cnt_ok;
        pop_bad   = rd_pop_cnt > rd_avail;
        push_fire = wr_valid && wr_ready && cnt_ok && !flush;
        pop_fire  = !pop_bad && !flush;
        push_cnt  = push_fire ? OCC_W'(wr_cnt) : '0;
        pop_cnt   = pop_fire ? OCC_W'(rd_pop_cnt) : '0;

        wr_ptr_d  = ptr_add(wr_ptr_q, push_cnt);
        rd_ptr_d  = ptr_add(rd_ptr_q, pop_cnt);
        occ_d     = occ_q + push_cnt - pop_cnt;
        err_d     = !flush && (push_bad || pop_bad);

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end
    end

    // Scatter: entry e takes lane (e - wr_ptr) mod DEPTH when that lane is valid.
    always_comb begin
        ring_d = ring_q;
        offset = '0;
        for (int e = 0; e < DEPTH; e++) begin
            offset = PTR_W'(e) - wr_ptr_q;
            if (push_fire && (offset < PTR_W'(wr_cnt))) begin
                ring_d[e] = wr_data[offset[LANE_W-1:0]];
            end
        end
    end

    // NOTE: state flops use non-blocking assignment so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            err_q    <= err_d;
        end
    end

    // NOTE: ring storage is deliberately not reset; unread entries are masked
    // off by rd_avail, so clearing them would only add reset fan-out.
    always_ff @(posedge clk) begin
        ring_q <= ring_d;
    end

    ring_gather u_gather (
        .ring     (ring_q),
        .rd_ptr   (rd_ptr_q),
        .rd_avail (rd_avail),
        .lanes    (rd_data)
    );

endmodule

// File: tb/tb_lane_unpack_fifo.sv
// Self-checking bench for lane_unpack_fifo: directed corner cases followed by
// random traffic, all compared against a queue-based model of the FIFO.
module tb_lane_unpack_fifo;
    import dfd_unpack_pkg::*;

    logic                   clk = 1'b0;
    logic                   reset_n = 1'b0;
    logic                   flush = 1'b0;
    logic                   wr_valid = 1'b0;
    logic                   wr_ready;
    logic   [IN_CNT_W-1:0]  wr_cnt = '0;
    entry_t [NUM_IN-1:0]    wr_data = '0;
    entry_t [NUM_OUT-1:0]   rd_data;
    logic   [OUT_CNT_W-1:0] rd_avail;
    logic   [OUT_CNT_W-1:0] rd_pop_cnt = '0;
    logic   [OCC_W-1:0]     occupancy;
    logic                   err;

    entry_t mq[$];
    logic   exp_err = 1'b0;
    int     total = 0;
    int     bad = 0;

    lane_unpack_fifo dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (flush),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_cnt     (wr_cnt),
        .wr_data    (wr_data),
        .rd_data    (rd_data),
        .rd_avail   (rd_avail),
        .rd_pop_cnt (rd_pop_cnt),
        .occupancy  (occupancy),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_avail();
        return (mq.size() > NUM_OUT) ? NUM_OUT : mq.size();
    endfunction

    task automatic check_all();
        int avail;
        avail = model_avail();
        check("occupancy", 32'(occupancy), 32'(mq.size()));
        check("rd_avail", 32'(rd_avail), 32'(avail));
        check("wr_ready", 32'(wr_ready), 32'((DEPTH - mq.size()) >= NUM_IN));
        check("err", 32'(err), 32'(exp_err));
        for (int j = 0; j < NUM_OUT; j++) begin
            check($sformatf("rd_data[%0d]", j), 32'(rd_data[j]),
                  (j < avail) ? 32'(mq[j]) : 32'd0);
        end
    endtask

    // Reference behaviour: a plain queue, oldest entry at the front.
    task automatic model_step();
        int  sz, avail, pop;
        bit  ready, cnt_ok;
        sz     = mq.size();
        avail  = model_avail();
        ready  = (DEPTH - sz) >= NUM_IN;
        cnt_ok = (wr_cnt >= 1) && (int'(wr_cnt) <= NUM_IN);
        pop    = int'(rd_pop_cnt);
        if (flush) begin
            mq.delete();
            exp_err = 1'b0;
        end else begin
            exp_err = (wr_valid && !cnt_ok) || (pop > avail);
            if (pop <= avail) begin
                for (int k = 0; k < pop; k++) void'(mq.pop_front());
            end
            if (wr_valid && ready && cnt_ok) begin
                for (int i = 0; i < int'(wr_cnt); i++) mq.push_back(wr_data[i]);
            end
        end
    endtask

    task automatic drive(input bit v, input int cnt, input int pop, input bit fl);
        wr_valid   = v;
        wr_cnt     = IN_CNT_W'(cnt);
        rd_pop_cnt = OUT_CNT_W'(pop);
        flush      = fl;
        for (int i = 0; i < NUM_IN; i++) wr_data[i] = entry_t'($urandom);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        drive(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check_all();
        check("rst_occ", 32'(occupancy), 32'd0);
        check("rst_ready", 32'(wr_ready), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;

        // Basic push of three entries.
        drive(1, 3, 0, 0);
        wr_data[0] = 10'h2A1;
        wr_data[1] = 10'h155;
        wr_data[2] = 10'h3C3;
        cycle();
        check("abc_avail", 32'(rd_avail), 32'd3);
        check("abc_lane0", 32'(rd_data[0]), 32'h2A1);
        check("abc_lane2", 32'(rd_data[2]), 32'h3C3);
        check("abc_lane3", 32'(rd_data[3]), 32'd0);

        drive(0, 0, 0, 1);
        cycle();

        // Fill to DEPTH with back-to-back pushes of four.
        for (int n = 0; n < 4; n++) begin
            drive(1, 4, 0, 0);
            cycle();
        end
        check("full_occ", 32'(occupancy), 32'd16);
        check("full_ready", 32'(wr_ready), 32'd0);
        drive(1, 4, 0, 0);
        cycle();
        check("full_drop_occ", 32'(occupancy), 32'd16);
        check("full_drop_err", 32'(err), 32'd0);
        drive(0, 0, 3, 0);
        cycle();
        check("occ13_ready", 32'(wr_ready), 32'd0);
        drive(0, 0, 1, 0);
        cycle();
        check("occ12_ready", 32'(wr_ready), 32'd1);

        // Walk rd_ptr to 14, then place six entries straddling 15 -> 0.
        drive(0, 0, 8, 0);
        cycle();
        drive(0, 0, 2, 0);
        cycle();
        drive(1, 4, 0, 0);
        cycle();
        check("wrap_avail", 32'(rd_avail), 32'd6);
        drive(0, 0, 6, 0);
        cycle();
        check("wrap_empty", 32'(occupancy), 32'd0);

        // Simultaneous push 4 / pop 5 at occupancy 8.
        drive(1, 4, 0, 0);
        cycle();
        drive(1, 4, 0, 0);
        cycle();
        drive(1, 4, 5, 0);
        cycle();
        check("pushpop_occ", 32'(occupancy), 32'd7);

        // Illegal pop, then illegal push count.
        drive(0, 0, 5, 0);
        cycle();
        drive(0, 0, 5, 0);
        cycle();
        check("badpop_err", 32'(err), 32'd1);
        check("badpop_occ", 32'(occupancy), 32'd2);
        drive(0, 0, 0, 0);
        cycle();
        check("badpop_pulse", 32'(err), 32'd0);
        drive(1, 0, 0, 0);
        cycle();
        check("badpush_err", 32'(err), 32'd1);
        check("badpush_occ", 32'(occupancy), 32'd2);
        drive(0, 0, 0, 0);
        cycle();

        // Flush at occupancy 9 with a concurrent push.
        drive(1, 4, 0, 0);
        cycle();
        drive(1, 3, 0, 0);
        cycle();
        check("preflush_occ", 32'(occupancy), 32'd9);
        drive(1, 2, 0, 1);
        cycle();
        check("flush_occ", 32'(occupancy), 32'd0);
        check("flush_ready", 32'(wr_ready), 32'd1);
        check("flush_err", 32'(err), 32'd0);

        // Random traffic with an asynchronous reset in the middle.
        for (int it = 0; it < 400; it++) begin
            int r, cnt, pop;
            r   = $urandom_range(0, 19);
            cnt = (r == 0) ? 0 : (r == 1) ? $urandom_range(5, 7) : $urandom_range(1, 4);
            pop = ($urandom_range(0, 15) == 0) ? $urandom_range(0, NUM_OUT)
                                               : $urandom_range(0, model_avail());
            drive($urandom_range(0, 3) != 0, cnt, pop, $urandom_range(0, 39) == 0);
            cycle();
            if (it == 200) begin
                drive(1, 4, 0, 0);
                reset_n = 1'b0;
                #1;
                mq.delete();
                exp_err = 1'b0;
                check_all();
                check("async_rst_occ", 32'(occupancy), 32'd0);
                @(negedge clk);
                drive(0, 0, 0, 0);
                reset_n = 1'b1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
